cpu_rp2a03_dma_controller: RTL and testbench

- Sequences all RP2A03 DMA traffic on the CPU bus: sprite OAM DMA (write to $4014) and DMC sample fetches requested by the APU DMC channel.
- Halts the 6502 core, aligns transfers to get/put CPU cycles and arbitrates the shared bus, with DMC taking priority over OAM.
- Sits between the CPU core, the APU and the CPU bus multiplexer.

---
 rtl/cpu_rp2a03_dma_controller.sv | 103 ++++++++++
 tb/tb_cpu_rp2a03_dma_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_rp2a03_dma_controller.sv
// cpu_rp2a03_dma_controller: halts the 6502 core and sequences OAM and DMC DMA on the CPU bus
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   cpu_ce_i, cpu_rd_cycle_i          CPU cycle-end strobe; the ending cycle is a read
//   cpu_halt_o, dma_active_o          CPU stall; DMA owns the bus this cycle
//   oam_dma_start_i, oam_dma_page_i   $4014 write pulse and page byte
//   dmc_dma_exe_i, dmc_dma_addr_i     DMC fetch request level and address
//   dmc_dma_rd_o, dmc_dma_rd_data_o   DMC byte delivery pulse and byte
//   bus_addr_o, bus_rd_o, bus_wr_o    DMA bus address and strobes
//   bus_wr_data_o, bus_rd_data_i      DMA write data, bus read data
module cpu_rp2a03_dma_controller #(
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          OAM_LENGTH    = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_rd_cycle_i,
    output logic        cpu_halt_o,
    output logic        dma_active_o,
    input  logic        oam_dma_start_i,
    input  logic [7:0]  oam_dma_page_i,
    input  logic        dmc_dma_exe_i,
    input  logic [15:0] dmc_dma_addr_i,
    output logic        dmc_dma_rd_o,
    output logic [7:0]  dmc_dma_rd_data_o,
    output logic [15:0] bus_addr_o,
    output logic        bus_rd_o,
    output logic        bus_wr_o,
    output logic [7:0]  bus_wr_data_o,
    input  logic [7:0]  bus_rd_data_i
);
    typedef enum logic [2:0] {IDLE, HALT, DUMMY, ALIGN, DMC_RD, OAM_RD, OAM_WR} state_e;
    localparam logic [7:0] LAST = 8'(OAM_LENGTH - 1);
    state_e      state_q, state_d, arb_d;
    logic        parity_q, oam_pending_q, halt_q, bus_rd_q, bus_wr_q, dmc_rd_q;
    logic        dmc_req, oam_left, get_next;
    logic [7:0]  page_q, index_q, idx_next, bus_wr_data_q, dmc_rd_data_q;
    logic [15:0] bus_addr_q, bus_addr_d;
    always_comb begin
        // the request that is being served in this very cycle must not be served twice
        dmc_req  = dmc_dma_exe_i && state_q != DMC_RD;
        oam_left = oam_pending_q && !(state_q == OAM_WR && index_q == LAST);
        // parity describes the current cycle, so the cycle being entered is a get when this one is a put
        get_next = parity_q;
        idx_next = state_q == OAM_WR ? index_q + 8'd1 : index_q;
        arb_d    = get_next && dmc_req  ? DMC_RD :
                   get_next && oam_left ? OAM_RD :
                   state_q == OAM_RD    ? OAM_WR :
                   dmc_req || oam_left  ? ALIGN  : IDLE;
        state_d  = state_q == IDLE ? ((dmc_req || oam_pending_q) && cpu_rd_cycle_i ? HALT : IDLE) :
                   state_q == HALT && dmc_req && !oam_pending_q ? DUMMY : arb_d;
        bus_addr_d = state_d == DMC_RD ? dmc_dma_addr_i :
                     state_d == OAM_RD ? {page_q, idx_next} :
                     state_d == OAM_WR ? OAM_DATA_ADDR : 16'h0000;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            parity_q      <= 1'b0;
            oam_pending_q <= 1'b0;
            page_q        <= '0;
            index_q       <= '0;
            halt_q        <= 1'b0;
            bus_rd_q      <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            dmc_rd_q      <= 1'b0;
            dmc_rd_data_q <= '0;
        end else begin
            dmc_rd_q <= cpu_ce_i && state_q == DMC_RD;
            if (cpu_ce_i && state_q == DMC_RD) dmc_rd_data_q <= bus_rd_data_i;
            if (oam_dma_start_i && !oam_pending_q) begin
                oam_pending_q <= 1'b1;
                page_q        <= oam_dma_page_i;
                index_q       <= '0;
            end
            if (cpu_ce_i) begin
                parity_q      <= ~parity_q;
                state_q       <= state_d;
                halt_q        <= state_d != IDLE;
                bus_rd_q      <= state_d == DMC_RD || state_d == OAM_RD;
                bus_wr_q      <= state_d == OAM_WR;
                bus_addr_q    <= bus_addr_d;
                // OAM_WR always directly follows its OAM_RD, so the byte is taken straight off the bus
                bus_wr_data_q <= state_d == OAM_WR ? bus_rd_data_i : 8'h00;
                if (state_q == OAM_WR) begin
                    index_q <= idx_next;
                    if (index_q == LAST) oam_pending_q <= 1'b0;
                end
            end
        end
    end
    assign cpu_halt_o        = halt_q;
    assign bus_rd_o          = bus_rd_q;
    assign bus_wr_o          = bus_wr_q;
    assign dma_active_o      = bus_rd_q | bus_wr_q;
    assign bus_addr_o        = bus_addr_q;
    assign bus_wr_data_o     = bus_wr_data_q;
    assign dmc_dma_rd_o      = dmc_rd_q;
    assign dmc_dma_rd_data_o = dmc_rd_data_q;
endmodule

// File: tb/tb_cpu_rp2a03_dma_controller.sv
// tb_cpu_rp2a03_dma_controller: schedule-model bench for the RP2A03 DMA controller
module tb_cpu_rp2a03_dma_controller;
    localparam int N = 4096;
    logic        clk = 1'b0, rst_i = 1'b1, cpu_ce_i = 1'b0, cpu_rd_cycle_i = 1'b1;
    logic        oam_dma_start_i = 1'b0, dmc_dma_exe_i = 1'b0;
    logic [7:0]  oam_dma_page_i = 8'h00;
    logic [15:0] dmc_dma_addr_i = 16'h0000;
    logic [7:0]  bus_rd_data_i;
    logic        cpu_halt_o, dma_active_o, dmc_dma_rd_o, bus_rd_o, bus_wr_o;
    logic [7:0]  dmc_dma_rd_data_o, bus_wr_data_o;
    logic [15:0] bus_addr_o;
    logic        e_halt [N], e_rd [N], e_wr [N], e_dmc [N];
    logic [15:0] e_addr [N];
    logic [7:0]  e_wd [N], e_dd [N];
    int          cyc = 0, rst_cyc = 0, ph = 0, n_tests = 0, n_fail = 0;
    int          obs_halt = 0, obs_wr = 0, obs_pulse = 0, obs_p3 = 0;
    int          h, g, last, s_h, s_p, s_w, s_3, c;
    logic        ce_prev = 1'b0, armed = 1'b0;
    logic [7:0]  last_wd = 8'h00;
    cpu_rp2a03_dma_controller dut (
        .clk_i(clk), .rst_i(rst_i), .cpu_ce_i(cpu_ce_i), .cpu_rd_cycle_i(cpu_rd_cycle_i),
        .cpu_halt_o(cpu_halt_o), .dma_active_o(dma_active_o),
        .oam_dma_start_i(oam_dma_start_i), .oam_dma_page_i(oam_dma_page_i),
        .dmc_dma_exe_i(dmc_dma_exe_i), .dmc_dma_addr_i(dmc_dma_addr_i),
        .dmc_dma_rd_o(dmc_dma_rd_o), .dmc_dma_rd_data_o(dmc_dma_rd_data_o),
        .bus_addr_o(bus_addr_o), .bus_rd_o(bus_rd_o), .bus_wr_o(bus_wr_o),
        .bus_wr_data_o(bus_wr_data_o), .bus_rd_data_i(bus_rd_data_i)
    );
    always #5 clk = ~clk;
    // memory: DMC sample bytes at C000/C123, everything else returns its low address byte
    always_comb bus_rd_data_i = bus_addr_o == 16'hC000 ? 8'h5A : bus_addr_o == 16'hC123 ? 8'hA7 : bus_addr_o[7:0];
    initial begin
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            cpu_ce_i = (ph == 2);
            ph = (ph + 1) % 3;
        end
    end
    always @(posedge clk) begin
        cyc     <= cyc + int'(cpu_ce_i);
        ce_prev <= cpu_ce_i;
    end
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
    function automatic bit is_get(input int k);
        return ((k - rst_cyc) % 2) == 0;
    endfunction
    task automatic clear_from(input int k);
        for (int i = k; i < N; i++) begin
            e_halt[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_dmc[i] = 0;
            e_addr[i] = 16'h0000; e_wd[i] = 8'h00; e_dd[i] = 8'h00;
        end
    endtask
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask
    // standalone DMC fetch halted at cycle hh: the read lands on the first get cycle after the dummy slot
    task automatic exp_dmc(input int hh, input logic [15:0] a, input logic [7:0] d, output int gg);
        gg = is_get(hh) ? hh + 2 : hh + 3;
        for (int k = hh; k <= gg; k++) e_halt[k] = 1;
        e_rd[gg] = 1; e_addr[gg] = a; e_dmc[gg] = 1; e_dd[gg] = d;
    endtask
    // OAM DMA halted at hh; byte i read on get cycle f+2i, written on the next put.
    // A DMC request raised during cycle col takes the first get cycle after it and pushes later reads by 2.
    task automatic exp_oam(input int hh, input logic [7:0] pg, input int col, input logic [15:0] da,
                           input logic [7:0] dd, output int gg, output int ll);
        int f;
        int r;
        f  = is_get(hh + 1) ? hh + 1 : hh + 2;
        gg = col < 0 ? -1 : is_get(col + 1) ? col + 1 : col + 2;
        for (int i = 0; i < 256; i++) begin
            r = f + 2 * i;
            if (gg >= 0 && r >= gg) r += 2;
            e_rd[r] = 1; e_addr[r] = {pg, 8'(i)};
            e_wr[r + 1] = 1; e_addr[r + 1] = 16'h2004; e_wd[r + 1] = 8'(i);
        end
        if (gg >= 0) begin
            e_rd[gg] = 1; e_addr[gg] = da; e_dmc[gg] = 1; e_dd[gg] = dd;
        end
        ll = f + 511 + (gg >= 0 ? 2 : 0);
        for (int k = hh; k <= ll; k++) e_halt[k] = 1;
    endtask
    task automatic tick();
        logic [27:0] got, want;
        @(negedge clk);
        if (!rst_i && armed && cpu_ce_i && cyc < N) begin
            n_tests++;
            got  = {cpu_halt_o, dma_active_o, bus_rd_o, bus_wr_o, bus_addr_o, bus_wr_data_o};
            want = {e_halt[cyc], e_rd[cyc] | e_wr[cyc], e_rd[cyc], e_wr[cyc], e_addr[cyc], e_wd[cyc]};
            if (got !== want) begin
                n_fail++;
                $display("FAIL cycle %0d bus: got halt=%b act=%b rd=%b wr=%b addr=%h wd=%h, want halt=%b act=%b rd=%b wr=%b addr=%h wd=%h",
                         cyc, got[27], got[26], got[25], got[24], got[23:8], got[7:0],
                         want[27], want[26], want[25], want[24], want[23:8], want[7:0]);
            end
            obs_halt += int'(cpu_halt_o);
            obs_wr   += int'(bus_wr_o);
            if (bus_wr_o) last_wd = bus_wr_data_o;
            if (bus_rd_o && bus_addr_o[15:8] == 8'h03) obs_p3++;
        end
        if (!rst_i && armed && ce_prev && cyc > 0 && cyc <= N) begin
            n_tests++;
            if (dmc_dma_rd_o !== e_dmc[cyc - 1] || (e_dmc[cyc - 1] && dmc_dma_rd_data_o !== e_dd[cyc - 1])) begin
                n_fail++;
                $display("FAIL cycle %0d dmc pulse: got rd=%b data=%h, want rd=%b data=%h",
                         cyc - 1, dmc_dma_rd_o, dmc_dma_rd_data_o, e_dmc[cyc - 1], e_dd[cyc - 1]);
            end
            if (dmc_dma_rd_o) obs_pulse++;
        end
    endtask
    task automatic sync();
        do tick(); while (!ce_prev);
    endtask
    task automatic wait_until(input int k);
        while (cyc < k) sync();
    endtask
    task automatic start_oam(input logic [7:0] pg);
        oam_dma_page_i  = pg;
        oam_dma_start_i = 1;
        tick();
        oam_dma_start_i = 0;
    endtask
    initial begin
        clear_from(0);
        repeat (4) tick();
        sync();
        rst_i = 0; rst_cyc = cyc; armed = 1;
        tick();
        chk("reset halt", 32'(cpu_halt_o), 0);
        chk("reset active", 32'(dma_active_o), 0);
        chk("reset addr", 32'(bus_addr_o), 0);
        chk("reset dmc data", 32'(dmc_dma_rd_data_o), 0);
        // DMC with HALT on a get cycle: HALT, DUMMY, DMC_RD
        sync();
        if (!is_get(cyc + 1)) sync();
        h = cyc + 1; s_h = obs_halt; s_p = obs_pulse;
        dmc_dma_addr_i = 16'hC000; dmc_dma_exe_i = 1;
        exp_dmc(h, 16'hC000, 8'h5A, g);
        wait_until(g + 1); dmc_dma_exe_i = 0;
        wait_until(g + 4);
        chk("dmc get halt len", 32'(obs_halt - s_h), 3);
        chk("dmc get pulses", 32'(obs_pulse - s_p), 1);
        chk("dmc get data", 32'(dmc_dma_rd_data_o), 32'h5A);
        // DMC with HALT on a put cycle needs an ALIGN slot
        if (is_get(cyc + 1)) sync();
        h = cyc + 1; s_h = obs_halt; s_p = obs_pulse;
        dmc_dma_exe_i = 1;
        exp_dmc(h, 16'hC000, 8'h5A, g);
        wait_until(g + 1); dmc_dma_exe_i = 0;
        wait_until(g + 4);
        chk("dmc put halt len", 32'(obs_halt - s_h), 4);
        chk("dmc put pulses", 32'(obs_pulse - s_p), 1);
        // request during three CPU write cycles, then a read
        if (!is_get(cyc + 4)) sync();
        c = cyc; s_h = obs_halt;
        cpu_rd_cycle_i = 0; dmc_dma_exe_i = 1;
        exp_dmc(c + 4, 16'hC000, 8'h5A, g);
        wait_until(c + 3); cpu_rd_cycle_i = 1;
        wait_until(g + 1); dmc_dma_exe_i = 0;
        wait_until(g + 4);
        chk("defer halt len", 32'(obs_halt - s_h), 3);
        // standalone OAM from a put-aligned HALT
        if (is_get(cyc + 1)) sync();
        h = cyc + 1; s_h = obs_halt; s_w = obs_wr;
        exp_oam(h, 8'h02, -1, 16'h0000, 8'h00, g, last);
        start_oam(8'h02);
        wait_until(last + 4);
        chk("oam halt len", 32'(obs_halt - s_h), 513);
        chk("oam writes", 32'(obs_wr - s_w), 256);
        chk("oam last byte", 32'(last_wd), 32'hFF);
        chk("oam idle after", 32'(cpu_halt_o), 0);
        // DMC collision while OAM is about to read index 40
        if (is_get(cyc + 1)) sync();
        h = cyc + 1; s_h = obs_halt; s_p = obs_pulse;
        c = h + 1 + 127;
        exp_oam(h, 8'h02, c, 16'hC123, 8'hA7, g, last);
        start_oam(8'h02);
        wait_until(c);
        dmc_dma_addr_i = 16'hC123; dmc_dma_exe_i = 1;
        wait_until(g + 1); dmc_dma_exe_i = 0;
        wait_until(last + 4);
        chk("collision halt len", 32'(obs_halt - s_h), 515);
        chk("collision pulses", 32'(obs_pulse - s_p), 1);
        chk("collision data", 32'(dmc_dma_rd_data_o), 32'hA7);
        // reset while OAM reads index 80
        if (is_get(cyc + 1)) sync();
        h = cyc + 1;
        exp_oam(h, 8'h02, -1, 16'h0000, 8'h00, g, last);
        start_oam(8'h02);
        wait_until(h + 1 + 256);
        rst_i = 1;
        clear_from(cyc);
        tick();
        chk("rst halt", 32'(cpu_halt_o), 0);
        chk("rst active", 32'(dma_active_o), 0);
        chk("rst rd", 32'(bus_rd_o), 0);
        chk("rst wr", 32'(bus_wr_o), 0);
        chk("rst addr", 32'(bus_addr_o), 0);
        chk("rst wdata", 32'(bus_wr_data_o), 0);
        chk("rst dmc rd", 32'(dmc_dma_rd_o), 0);
        chk("rst dmc data", 32'(dmc_dma_rd_data_o), 0);
        repeat (3) tick();
        sync();
        rst_i = 0; rst_cyc = cyc;
        // restart from index 0 with a get-aligned HALT; a second start with page 03 is ignored
        sync();
        if (!is_get(cyc + 1)) sync();
        h = cyc + 1; s_h = obs_halt; s_w = obs_wr; s_3 = obs_p3;
        exp_oam(h, 8'h02, -1, 16'h0000, 8'h00, g, last);
        start_oam(8'h02);
        wait_until(h + 22);
        start_oam(8'h03);
        wait_until(last + 4);
        chk("restart halt len", 32'(obs_halt - s_h), 514);
        chk("restart writes", 32'(obs_wr - s_w), 256);
        chk("dup page reads", 32'(obs_p3 - s_3), 0);
        chk("restart idle after", 32'(cpu_halt_o), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
